// File: rtl/jtpopeye_dma.sv
// Vertical-blank object DMA: requests the CPU bus, copies DMA_LEN bytes from main RAM into the object buffer.
// Optional checksum of each completed transfer when JTPOPEYE_DMA_CHKSUM_EN is defined.
module jtpopeye_dma #(
    parameter logic [9:0]  DMA_START = 10'h000,
    parameter logic [10:0] DMA_LEN   = 11'd768
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       VB,
    input  logic       busak_n,
    input  logic [7:0] DD_DMA,
    output logic       busrq_n,
    output logic       dma_cs,
    output logic [9:0] AD_DMA,
    output logic       obj_we,
    output logic [9:0] obj_addr,
    output logic [7:0] obj_din,
    output logic       busy,
    output logic       overrun,
    output logic       abort,
    output logic [7:0] chksum
);

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam logic [AW-1:0] CNT_LAST = AW'(DMA_LEN - 11'd1);

    typedef enum logic [2:0] {IDLE, REQ, XFER, FLUSH, REL} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic          vbl;
    logic          trigger;
    logic          we_nx, abort_nx, done_nx, overrun_nx;
    logic          xfer_nx, busrq_n_nx, busy_nx;
    logic [AW-1:0] ad_nx, obj_addr_nx;
    logic [DW-1:0] obj_din_nx;

    // Next state; outputs are decoded from the next state so they register alongside it
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        we_nx       = 1'b0;
        abort_nx    = 1'b0;
        done_nx     = 1'b0;
        trigger     = VB & ~vbl;
        case (state)
            IDLE:  if (trigger) state_nx = REQ;
            REQ:   if (!busak_n) begin
                       state_nx = XFER;
                       cnt_nx   = '0;
                   end
            XFER:  if (busak_n) begin
                       state_nx = REL;
                       abort_nx = 1'b1;
                   end else begin
                       we_nx = 1'b1;
                       if (cnt == CNT_LAST) state_nx = FLUSH;
                       else                 cnt_nx   = cnt + AW'(1);
                   end
            FLUSH: begin
                       state_nx = REL;
                       if (busak_n) abort_nx = 1'b1;
                       else         done_nx  = 1'b1;
                   end
            REL:   if (busak_n) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        overrun_nx  = trigger && (state != IDLE);
        xfer_nx     = (state_nx == XFER) || (state_nx == FLUSH);
        busrq_n_nx  = !(xfer_nx || (state_nx == REQ));
        busy_nx     = (state_nx != IDLE);
        ad_nx       = xfer_nx ? DMA_START + cnt_nx : '0;
        // Data for the address issued last tick is valid now; write it with that address's count
        obj_addr_nx = we_nx ? cnt : '0;
        obj_din_nx  = we_nx ? DD_DMA : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            vbl      <= 1'b0;
            busrq_n  <= 1'b1;
            dma_cs   <= 1'b0;
            AD_DMA   <= '0;
            obj_we   <= 1'b0;
            obj_addr <= '0;
            obj_din  <= '0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            abort    <= 1'b0;
        end else if (cen) begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            vbl      <= VB;
            busrq_n  <= busrq_n_nx;
            dma_cs   <= xfer_nx;
            AD_DMA   <= ad_nx;
            obj_we   <= we_nx;
            obj_addr <= obj_addr_nx;
            obj_din  <= obj_din_nx;
            busy     <= busy_nx;
            overrun  <= overrun_nx;
            abort    <= abort_nx;
        end
    end

`ifdef JTPOPEYE_DMA_CHKSUM_EN
    logic [DW-1:0] acc, acc_sum;

    assign acc_sum = acc + (obj_we ? obj_din : DW'(0));

    // The last byte is on obj_din during FLUSH, so the result loads from acc_sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            chksum <= '0;
        end else if (cen) begin
            if (state == REQ && state_nx == XFER) acc <= '0;
            else                                  acc <= acc_sum;
            if (done_nx) chksum <= acc_sum;
        end
    end
`else
    assign chksum = 8'h00;
`endif

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Directed bench for jtpopeye_dma: full transfer, address wrap, overrun, abort and mid-transfer reset.
module tb_jtpopeye_dma;

    logic       clk, rst_n, cen, VB, busak_n, busak2_n;
    logic [7:0] DD_DMA, DD2;
    logic       busrq_n, dma_cs, obj_we, busy, overrun, abort;
    logic [9:0] AD_DMA, obj_addr;
    logic [7:0] obj_din, chksum;
    logic       busrq2_n, dma_cs2, obj_we2, busy2, overrun2, abort2;
    logic [9:0] AD2, obj_addr2;
    logic [7:0] obj_din2, chksum2;

`ifdef JTPOPEYE_DMA_CHKSUM_EN
    localparam logic [7:0] EXP_SUM = 8'h80;
`else
    localparam logic [7:0] EXP_SUM = 8'h00;
`endif

    int total = 0, bad = 0;
    int rq_cnt = 0, rq2_cnt = 0;
    bit ack_hold = 0, chk2 = 0;
    int ad2_idx = 0, we2_n = 0;
    logic [9:0] exp2 [5];
    int we_n, ov_n, ab_n;
    bit timeout, reached;

    jtpopeye_dma dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .VB(VB), .busak_n(busak_n), .DD_DMA(DD_DMA),
        .busrq_n(busrq_n), .dma_cs(dma_cs), .AD_DMA(AD_DMA), .obj_we(obj_we),
        .obj_addr(obj_addr), .obj_din(obj_din), .busy(busy), .overrun(overrun),
        .abort(abort), .chksum(chksum)
    );

    jtpopeye_dma #(.DMA_START(10'h3FE), .DMA_LEN(11'd4)) dut2 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .VB(VB), .busak_n(busak2_n), .DD_DMA(DD2),
        .busrq_n(busrq2_n), .dma_cs(dma_cs2), .AD_DMA(AD2), .obj_we(obj_we2),
        .obj_addr(obj_addr2), .obj_din(obj_din2), .busy(busy2), .overrun(overrun2),
        .abort(abort2), .chksum(chksum2)
    );

    // Main RAM holds RAM[i] = i[7:0]
    assign DD_DMA = AD_DMA[7:0];
    assign DD2    = AD2[7:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cen tick followed by one gated clock; ends 1 time unit after a posedge
    task tick();
        cen = 1'b1;
        @(posedge clk); #1;
        cen = 1'b0;
        @(posedge clk); #1;
    endtask

    // Bus arbiters: grant three ticks after the request is seen, release when the request drops
    task arbiter();
        if (!busrq_n && !ack_hold) begin
            if (rq_cnt >= 3) busak_n = 1'b0;
            else             rq_cnt++;
        end else begin
            busak_n = 1'b1;
            rq_cnt  = 0;
        end
        if (!busrq2_n) begin
            if (rq2_cnt >= 3) busak2_n = 1'b0;
            else              rq2_cnt++;
        end else begin
            busak2_n = 1'b1;
            rq2_cnt  = 0;
        end
    endtask

    task run(input int abort_at, input int ov_at);
        bit seen_rel;
        logic [9:0] a2;
        seen_rel = 0;
        we_n = 0; ov_n = 0; ab_n = 0; timeout = 1;
        for (int t = 0; t < 3000; t++) begin
            tick();
            if (overrun) ov_n++;
            if (abort)   ab_n++;
            if (obj_we) begin
                chk("we_addr", 32'(obj_addr), 32'(we_n));
                chk("we_din", 32'(obj_din), 32'(we_n % 256));
                we_n++;
            end
            if (!dma_cs) begin
                chk("idle_we", 32'(obj_we), 0);
                chk("idle_ad", 32'(AD_DMA), 0);
                chk("idle_oa", 32'(obj_addr), 0);
            end
            if (busrq_n && !seen_rel) begin
                seen_rel = 1;
                chk("rel_busy", 32'(busy), 1);
                chk("rel_cs", 32'(dma_cs), 0);
            end
            if (chk2) begin
                if (dma_cs2) begin
                    if (ad2_idx < 5) chk("wrap_ad", 32'(AD2), 32'(exp2[ad2_idx]));
                    ad2_idx++;
                end
                if (obj_we2) begin
                    a2 = (we2_n < 5) ? exp2[we2_n] : 10'h0;
                    chk("wrap_oa", 32'(obj_addr2), 32'(we2_n));
                    chk("wrap_din", 32'(obj_din2), 32'(a2[7:0]));
                    we2_n++;
                end
            end
            if (ov_at >= 0 && dma_cs && AD_DMA == 10'(ov_at))     VB = 1'b0;
            if (ov_at >= 0 && dma_cs && AD_DMA == 10'(ov_at + 1)) VB = 1'b1;
            if (abort_at >= 0 && dma_cs && AD_DMA == 10'(abort_at)) ack_hold = 1;
            if (!busy) begin
                timeout = 0;
                break;
            end
            arbiter();
        end
        ack_hold = 0;
    endtask

    initial begin
        exp2[0] = 10'h3FE; exp2[1] = 10'h3FF; exp2[2] = 10'h000;
        exp2[3] = 10'h001; exp2[4] = 10'h001;
        rst_n = 1'b0; cen = 1'b1; VB = 1'b1; busak_n = 1'b1; busak2_n = 1'b1;

        // Reset holds everything regardless of clk and cen
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busrq", 32'(busrq_n), 1);
        chk("rst_cs", 32'(dma_cs), 0);
        chk("rst_we", 32'(obj_we), 0);
        chk("rst_ad", 32'(AD_DMA), 0);
        chk("rst_oa", 32'(obj_addr), 0);
        chk("rst_din", 32'(obj_din), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ov", 32'(overrun), 0);
        chk("rst_ab", 32'(abort), 0);
        chk("rst_sum", 32'(chksum), 0);

        // VB already high at release triggers on the first tick
        rst_n = 1'b1;
        tick();
        chk("vb_hi_rq", 32'(busrq_n), 0);
        chk("vb_hi_busy", 32'(busy), 1);
        chk("vb_hi_rq2", 32'(busrq2_n), 0);

        chk2 = 1;
        run(-1, -1);
        chk2 = 0;
        chk("full_timeout", 32'(timeout), 0);
        chk("full_we", 32'(we_n), 768);
        chk("full_ov", 32'(ov_n), 0);
        chk("full_ab", 32'(ab_n), 0);
        chk("full_sum", 32'(chksum), 32'(EXP_SUM));
        chk("wrap_nad", 32'(ad2_idx), 5);
        chk("wrap_nwe", 32'(we2_n), 4);

        // Trigger with grant already low: only to REQ, then overrun during XFER
        VB = 1'b0;
        tick();
        VB = 1'b1; busak_n = 1'b0;
        tick();
        chk("same_rq", 32'(busrq_n), 0);
        chk("same_cs", 32'(dma_cs), 0);
        run(-1, 10);
        chk("ov_timeout", 32'(timeout), 0);
        chk("ov_we", 32'(we_n), 768);
        chk("ov_cnt", 32'(ov_n), 1);
        chk("ov_ab", 32'(ab_n), 0);
        chk("ov_sum", 32'(chksum), 32'(EXP_SUM));

        // Grant lost at cnt=100
        VB = 1'b0;
        tick();
        VB = 1'b1;
        tick();
        chk("ab_rq", 32'(busrq_n), 0);
        run(100, -1);
        chk("ab_timeout", 32'(timeout), 0);
        chk("ab_we", 32'(we_n), 100);
        chk("ab_cnt", 32'(ab_n), 1);
        chk("ab_ov", 32'(ov_n), 0);
        chk("ab_sum", 32'(chksum), 32'(EXP_SUM));

        // Reset at cnt=50
        VB = 1'b0;
        tick();
        VB = 1'b1;
        tick();
        reached = 0;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (dma_cs && AD_DMA == 10'd50) begin
                reached = 1;
                break;
            end
            arbiter();
        end
        chk("mid_reached", 32'(reached), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_busrq", 32'(busrq_n), 1);
        chk("mid_cs", 32'(dma_cs), 0);
        chk("mid_we", 32'(obj_we), 0);
        chk("mid_ad", 32'(AD_DMA), 0);
        chk("mid_oa", 32'(obj_addr), 0);
        chk("mid_din", 32'(obj_din), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_sum", 32'(chksum), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_hold_we", 32'(obj_we), 0);
        chk("mid_hold_rq", 32'(busrq_n), 1);
        VB = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_busy", 32'(busy), 0);
        chk("post_rq", 32'(busrq_n), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
